// File: rtl/tmc_spi_responder_pkg.sv
// Shared register map, frame layout and FSM encoding for the TMC-style SPI responder.
// The motor_driver side uses the same addresses, so keep this list in step with it.
package tmc_spi_responder_pkg;

  localparam int FRAME_BITS = 40;

  localparam logic [6:0] ADDR_GCONF      = 7'h00;
  localparam logic [6:0] ADDR_GSTAT      = 7'h01;
  localparam logic [6:0] ADDR_IHOLD_IRUN = 7'h10;
  localparam logic [6:0] ADDR_TPOWERDOWN = 7'h11;
  localparam logic [6:0] ADDR_TPWMTHRS   = 7'h13;
  localparam logic [6:0] ADDR_THIGH      = 7'h15;
  localparam logic [6:0] ADDR_CHOPCONF   = 7'h6C;
  localparam logic [6:0] ADDR_DRV_STATUS = 7'h6F;
  localparam logic [6:0] ADDR_PWMCONF    = 7'h70;
  localparam logic [6:0] ADDR_LOST_STEPS = 7'h73;

  localparam logic [7:0] WRITE_ADDR = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
  } frame_t;

  function automatic logic isWritable(input logic [6:0] addr);
    case (addr)
      ADDR_GCONF, ADDR_GSTAT, ADDR_IHOLD_IRUN, ADDR_TPOWERDOWN, ADDR_TPWMTHRS,
      ADDR_THIGH, ADDR_CHOPCONF, ADDR_PWMCONF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Upper nibble is reserved and always reads as zero.
  function automatic logic [7:0] statusByte(input logic [1:0] gstat, input logic [31:0] drvStatus);
    return {4'b0000, drvStatus[31], drvStatus[24], gstat[1], gstat[0]};
  endfunction

endpackage

// File: rtl/tmc_spi_responder_if.sv
// SPI bus lines between an initiator (master) and the responder (slave).
interface tmc_spi_responder_if;
  logic sclk_in;
  logic cs_n_in;
  logic mosi_in;
  logic miso_out;

  modport master (output sclk_in, output cs_n_in, output mosi_in, input miso_out);
  modport slave  (input sclk_in, input cs_n_in, input mosi_in, output miso_out);
endinterface

// File: rtl/tmc_spi_responder_sync_edge.sv
// Multi-flop synchronizer followed by a one-flop edge detector with rise/fall pulses.
module tmc_spi_responder_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/tmc_spi_responder.sv
// SPI mode-3 target for 40-bit TMC2130-style frames: register file, status byte and
// read data that is returned one frame late (pipelined read latch).
module tmc_spi_responder
  import tmc_spi_responder_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] CHOPCONF_RST = 32'h00000000,
  parameter logic [31:0] GCONF_RST    = 32'h00000000
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  tmc_spi_responder_if.slave    spi,
  input  logic [31:0]           drv_status_in,
  input  logic                  drv_err_in,
  output logic [31:0]           gconf_out,
  output logic [31:0]           ihold_irun_out,
  output logic [31:0]           chopconf_out,
  output logic                  wr_strobe_out,
  output logic [6:0]            wr_addr_out,
  output logic                  frame_err_out
);

  logic sclkRise, sclkFall, csRise, csFall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosiSync;

  state_e      state_q, state_d;
  logic [39:0] tx_sr_q, tx_sr_d;
  logic [39:0] rx_sr_q, rx_sr_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic        miso_q, miso_d;
  logic [31:0] read_latch_q, read_latch_d;
  logic [31:0] gconf_q, gconf_d;
  logic [1:0]  gstat_q, gstat_d;
  logic [31:0] ihold_irun_q, ihold_irun_d;
  logic [31:0] tpowerdown_q, tpowerdown_d;
  logic [31:0] tpwmthrs_q, tpwmthrs_d;
  logic [31:0] thigh_q, thigh_d;
  logic [31:0] chopconf_q, chopconf_d;
  logic [31:0] pwmconf_q, pwmconf_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic        frame_err_q, frame_err_d;
  frame_t      frame;

  tmc_spi_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .d_i      (spi.sclk_in),
    .rise_o   (sclkRise),
    .fall_o   (sclkFall)
  );

  tmc_spi_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .d_i      (spi.cs_n_in),
    .rise_o   (csRise),
    .fall_o   (csFall)
  );

  // mosi only needs the same delay as sclk so it lines up with the detected rise.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi_in};
    end
  end

  assign mosiSync = mosi_sync_q[SYNC_STAGES-1];
  assign frame    = rx_sr_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      bitcnt_q     <= '0;
      miso_q       <= 1'b0;
      read_latch_q <= '0;
      gconf_q      <= GCONF_RST;
      gstat_q      <= 2'b01;
      ihold_irun_q <= '0;
      tpowerdown_q <= '0;
      tpwmthrs_q   <= '0;
      thigh_q      <= '0;
      chopconf_q   <= CHOPCONF_RST;
      pwmconf_q    <= '0;
      wr_strobe_q  <= 1'b0;
      wr_addr_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      bitcnt_q     <= bitcnt_d;
      miso_q       <= miso_d;
      read_latch_q <= read_latch_d;
      gconf_q      <= gconf_d;
      gstat_q      <= gstat_d;
      ihold_irun_q <= ihold_irun_d;
      tpowerdown_q <= tpowerdown_d;
      tpwmthrs_q   <= tpwmthrs_d;
      thigh_q      <= thigh_d;
      chopconf_q   <= chopconf_d;
      pwmconf_q    <= pwmconf_d;
      wr_strobe_q  <= wr_strobe_d;
      wr_addr_q    <= wr_addr_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    bitcnt_d     = bitcnt_q;
    miso_d       = miso_q;
    read_latch_d = read_latch_q;
    gconf_d      = gconf_q;
    gstat_d      = gstat_q;
    ihold_irun_d = ihold_irun_q;
    tpowerdown_d = tpowerdown_q;
    tpwmthrs_d   = tpwmthrs_q;
    thigh_d      = thigh_q;
    chopconf_d   = chopconf_q;
    pwmconf_d    = pwmconf_q;
    wr_strobe_d  = 1'b0;
    wr_addr_d    = wr_addr_q;
    frame_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (csFall) begin
          tx_sr_d  = {statusByte(gstat_q, drv_status_in), read_latch_q};
          miso_d   = tx_sr_d[39];
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (sclkRise) begin
          rx_sr_d = {rx_sr_q[38:0], mosiSync};
          if (bitcnt_q != 6'd63) begin
            bitcnt_d = bitcnt_q + 6'd1;
          end
        end
        // The leading fall of mode 3 presents bit 39, which is already on miso from the load.
        if (sclkFall && (bitcnt_q != 6'd0)) begin
          tx_sr_d = {tx_sr_q[38:0], 1'b0};
          miso_d  = tx_sr_q[38];
        end
        if (csRise) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
        if (bitcnt_q == 6'(FRAME_BITS)) begin
          if (frame.wr && isWritable(frame.addr)) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = frame.addr;
            case (frame.addr)
              ADDR_GCONF:      gconf_d      = frame.data;
              ADDR_GSTAT:      gstat_d      = gstat_q & ~frame.data[1:0];
              ADDR_IHOLD_IRUN: ihold_irun_d = frame.data;
              ADDR_TPOWERDOWN: tpowerdown_d = frame.data;
              ADDR_TPWMTHRS:   tpwmthrs_d   = frame.data;
              ADDR_THIGH:      thigh_d      = frame.data;
              ADDR_CHOPCONF:   chopconf_d   = frame.data;
              ADDR_PWMCONF:    pwmconf_d    = frame.data;
              default: ;
            endcase
          end
          case (frame.addr)
            ADDR_GCONF:      read_latch_d = gconf_d;
            ADDR_GSTAT:      read_latch_d = {30'd0, gstat_d};
            ADDR_IHOLD_IRUN: read_latch_d = ihold_irun_d;
            ADDR_TPOWERDOWN: read_latch_d = tpowerdown_d;
            ADDR_TPWMTHRS:   read_latch_d = tpwmthrs_d;
            ADDR_THIGH:      read_latch_d = thigh_d;
            ADDR_CHOPCONF:   read_latch_d = chopconf_d;
            ADDR_DRV_STATUS: read_latch_d = drv_status_in;
            ADDR_PWMCONF:    read_latch_d = pwmconf_d;
            default:         read_latch_d = '0;
          endcase
          if (!frame.wr && (frame.addr == ADDR_GSTAT)) begin
            gstat_d = 2'b00;
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A driver error arriving in the same cycle as a clear must not be lost.
    if (drv_err_in) begin
      gstat_d[1] = 1'b1;
    end
  end

  assign spi.miso_out   = miso_q & ~spi.cs_n_in;
  assign gconf_out      = gconf_q;
  assign ihold_irun_out = ihold_irun_q;
  assign chopconf_out   = chopconf_q;
  assign wr_strobe_out  = wr_strobe_q;
  assign wr_addr_out    = wr_addr_q;
  assign frame_err_out  = frame_err_q;

endmodule

// File: tb/tb_tmc_spi_responder.sv
// Self-checking bench: drives mode-3 SPI frames and compares against a register-map model.
module tb_tmc_spi_responder;
  import tmc_spi_responder_pkg::*;

  localparam logic [31:0] CHOP_RST_V  = 32'h000100C3;
  localparam logic [31:0] GCONF_RST_V = 32'h00000004;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] drvStatus;
  logic        drvErr;
  logic [31:0] gconfOut, iholdOut, chopOut;
  logic        wrStrobe, frameErr;
  logic [6:0]  wrAddr;

  int total = 0;
  int bad = 0;
  int strobeCnt = 0;
  int errCnt = 0;

  logic [31:0] mRegs [0:127];
  logic [31:0] mLatch;
  logic [6:0]  mWrAddr;

  tmc_spi_responder_if spiBus();

  tmc_spi_responder #(
    .SYNC_STAGES  (2),
    .CHOPCONF_RST (CHOP_RST_V),
    .GCONF_RST    (GCONF_RST_V)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset),
    .spi            (spiBus),
    .drv_status_in  (drvStatus),
    .drv_err_in     (drvErr),
    .gconf_out      (gconfOut),
    .ihold_irun_out (iholdOut),
    .chopconf_out   (chopOut),
    .wr_strobe_out  (wrStrobe),
    .wr_addr_out    (wrAddr),
    .frame_err_out  (frameErr)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    if (wrStrobe === 1'b1) strobeCnt++;
    if (frameErr === 1'b1) errCnt++;
  end

  function automatic logic isImpl(input logic [6:0] a);
    return a inside {7'h00, 7'h01, 7'h10, 7'h11, 7'h13, 7'h15, 7'h6C, 7'h6F, 7'h70};
  endfunction

  function automatic logic [31:0] mRead(input logic [6:0] a);
    if (a == 7'h6F) return drvStatus;
    if (!isImpl(a)) return 32'h0;
    return mRegs[a];
  endfunction

  function automatic logic [7:0] mStatus();
    return {4'h0, drvStatus[31], drvStatus[24], mRegs[1][1], mRegs[1][0]};
  endfunction

  task automatic modelReset();
    for (int a = 0; a < 128; a++) mRegs[a] = 32'h0;
    mRegs[7'h00] = GCONF_RST_V;
    mRegs[7'h6C] = CHOP_RST_V;
    mRegs[7'h01] = 32'h1;
    mLatch  = 32'h0;
    mWrAddr = 7'h0;
  endtask

  // Expected response is taken before the model absorbs the frame.
  task automatic modelFrame(input logic [39:0] f, input int nbits,
                            output logic [39:0] expResp, output int expStrobe);
    logic       wr;
    logic [6:0] a;
    logic [31:0] d;
    expResp   = {mStatus(), mLatch};
    expStrobe = 0;
    wr = f[39];
    a  = f[38:32];
    d  = f[31:0];
    if (nbits == 40) begin
      if (wr && isImpl(a) && a != 7'h6F) begin
        expStrobe = 1;
        mWrAddr   = a;
        if (a == 7'h01) mRegs[1] = mRegs[1] & ~d & 32'h3;
        else            mRegs[a] = d;
      end
      mLatch = mRead(a);
      if (!wr && a == 7'h01) mRegs[1] = 32'h0;
    end
  endtask

  task automatic applyStimulus(input logic [39:0] f, input int nbits, output logic [39:0] resp);
    resp = '0;
    spiBus.cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spiBus.sclk_in = 1'b0;
      spiBus.mosi_in = (i < 40) ? f[39-i] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i < 40) resp[39-i] = spiBus.miso_out;
      spiBus.sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    spiBus.cs_n_in = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulseDrvErr();
    drvErr = 1'b1;
    @(negedge clk);
    drvErr = 1'b0;
    mRegs[1] = mRegs[1] | 32'h2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    spiBus.sclk_in = 1'b1;
    spiBus.cs_n_in = 1'b1;
    spiBus.mosi_in = 1'b0;
    drvStatus = 32'h0;
    drvErr = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (spiBus.miso_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_miso got %b want 0", spiBus.miso_out); end
    total++; if (wrStrobe !== 1'b0 || frameErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes got %b%b want 00", wrStrobe, frameErr); end
    reset = 1'b0;
    modelReset();
    repeat (4) @(negedge clk);
    total++; if (gconfOut !== GCONF_RST_V) begin bad++; $display("[TB] FAIL reset_gconf got %h want %h", gconfOut, GCONF_RST_V); end
    total++; if (chopOut !== CHOP_RST_V) begin bad++; $display("[TB] FAIL reset_chopconf got %h want %h", chopOut, CHOP_RST_V); end
    total++; if (iholdOut !== 32'h0 || wrAddr !== 7'h0) begin bad++; $display("[TB] FAIL reset_ihold_addr got %h/%h want 0/0", iholdOut, wrAddr); end
  endtask

  task automatic test_gstat_read();
    logic [39:0] f, e, r;
    int es;
    f = {8'h01, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (r !== {8'h01, 32'h0} || r !== e) begin bad++; $display("[TB] FAIL gstat_first got %h want %h", r, e); end
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (r[31:0] !== 32'h1 || r[32] !== 1'b0 || r !== e) begin bad++; $display("[TB] FAIL gstat_second got %h want %h", r, e); end
  endtask

  task automatic test_write_chopconf();
    logic [39:0] f, e, r;
    int es, s0;
    f = {WRITE_ADDR | 8'h6C, 32'h300A8188};
    s0 = strobeCnt;
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (chopOut !== 32'h300A8188) begin bad++; $display("[TB] FAIL chop_write got %h want 300a8188", chopOut); end
    total++; if (strobeCnt - s0 !== 1) begin bad++; $display("[TB] FAIL chop_strobe got %0d want 1", strobeCnt - s0); end
    total++; if (wrAddr !== 7'h6C) begin bad++; $display("[TB] FAIL chop_addr got %h want 6c", wrAddr); end
    f = {8'h6C, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (r[31:0] !== 32'h300A8188 || r !== e) begin bad++; $display("[TB] FAIL chop_readback got %h want %h", r, e); end
  endtask

  task automatic test_short_frame();
    logic [39:0] f, e, r, mask;
    logic [31:0] latchBefore;
    int es, e0, s0;
    latchBefore = mLatch;
    f = {8'h80, 32'hDEADBEEF};
    e0 = errCnt;
    s0 = strobeCnt;
    modelFrame(f, 39, e, es);
    applyStimulus(f, 39, r);
    mask = {40{1'b1}} << 1;
    total++; if ((r & mask) !== (e & mask)) begin bad++; $display("[TB] FAIL short_resp got %h want %h", r & mask, e & mask); end
    total++; if (errCnt - e0 !== 1 || strobeCnt - s0 !== 0) begin bad++; $display("[TB] FAIL short_pulses got err=%0d strobe=%0d want 1/0", errCnt - e0, strobeCnt - s0); end
    total++; if (gconfOut !== mRegs[0]) begin bad++; $display("[TB] FAIL short_gconf got %h want %h", gconfOut, mRegs[0]); end
    f = {8'h10, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (r[31:0] !== latchBefore || r !== e) begin bad++; $display("[TB] FAIL short_latch got %h want %h", r, e); end
  endtask

  task automatic test_drv_status();
    logic [39:0] f, e, r;
    int es;
    drvStatus = 32'h81000000;
    f = {8'h6F, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    f = {8'h00, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if ((r[39:32] & 8'hFC) !== 8'h0C || r[31:0] !== 32'h81000000 || r !== e) begin bad++; $display("[TB] FAIL drv_status got %h want %h", r, e); end
    drvStatus = 32'h0;
  endtask

  task automatic test_drv_err();
    logic [39:0] f, e, r;
    int es;
    pulseDrvErr();
    f = {8'h01, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (r[33] !== 1'b1 || r !== e) begin bad++; $display("[TB] FAIL drv_err_flag got %h want %h", r, e); end
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (r[31:0] !== 32'h2 || r[33] !== 1'b0 || r !== e) begin bad++; $display("[TB] FAIL drv_err_clear got %h want %h", r, e); end
  endtask

  task automatic test_reset_midframe();
    logic [39:0] f, e, r;
    int es, s0;
    f = {WRITE_ADDR | 8'h6C, $urandom()};
    spiBus.cs_n_in = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      spiBus.sclk_in = 1'b0;
      spiBus.mosi_in = f[39-i];
      repeat (HALF) @(negedge clk);
      spiBus.sclk_in = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (chopOut !== CHOP_RST_V || spiBus.miso_out !== 1'b0) begin bad++; $display("[TB] FAIL midreset_state got %h/%b want %h/0", chopOut, spiBus.miso_out, CHOP_RST_V); end
    spiBus.cs_n_in = 1'b1;
    spiBus.sclk_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
    repeat (6) @(negedge clk);
    f = {WRITE_ADDR | 8'h6C, 32'hA5A55A5A};
    s0 = strobeCnt;
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (chopOut !== 32'hA5A55A5A || strobeCnt - s0 !== 1 || r !== e) begin bad++; $display("[TB] FAIL midreset_next got chop=%h resp=%h want %h/%h", chopOut, r, 32'hA5A55A5A, e); end
  endtask

  task automatic test_unimplemented();
    logic [39:0] f, e, r;
    int es, s0;
    logic [6:0] addrBefore;
    addrBefore = wrAddr;
    s0 = strobeCnt;
    f = {8'hFF, 32'h12345678};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    f = {8'hEF, 32'h5555AAAA};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (strobeCnt - s0 !== 0 || wrAddr !== addrBefore) begin bad++; $display("[TB] FAIL unimpl_strobe got %0d/%h want 0/%h", strobeCnt - s0, wrAddr, addrBefore); end
    f = {8'h7F, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    f = {8'h00, 32'h0};
    modelFrame(f, 40, e, es);
    applyStimulus(f, 40, r);
    total++; if (r[31:0] !== 32'h0 || r !== e) begin bad++; $display("[TB] FAIL unimpl_read got %h want %h", r, e); end
  endtask

  task automatic test_random();
    logic [6:0] addrList [12] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h13, 7'h15,
                                  7'h6C, 7'h6F, 7'h70, 7'h7F, 7'h22, 7'h05};
    logic [39:0] f, e, r, mask;
    int es, s0, e0, nbits, nEff;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) drvStatus = $urandom();
      if ($urandom_range(0, 4) == 0) pulseDrvErr();
      f = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, addrList[$urandom_range(0, 11)], $urandom()};
      case ($urandom_range(0, 7))
        0: nbits = 39;
        1: nbits = 41;
        2: nbits = $urandom_range(1, 38);
        default: nbits = 40;
      endcase
      nEff = (nbits > 40) ? 40 : nbits;
      mask = {40{1'b1}} << (40 - nEff);
      s0 = strobeCnt;
      e0 = errCnt;
      modelFrame(f, nbits, e, es);
      applyStimulus(f, nbits, r);
      total++; if ((r & mask) !== (e & mask)) begin bad++; $display("[TB] FAIL rand_resp[%0d] got %h want %h", n, r & mask, e & mask); end
      total++; if (strobeCnt - s0 !== es || errCnt - e0 !== ((nbits == 40) ? 0 : 1)) begin bad++; $display("[TB] FAIL rand_pulses[%0d] got s=%0d e=%0d want s=%0d bits=%0d", n, strobeCnt - s0, errCnt - e0, es, nbits); end
      total++; if (gconfOut !== mRegs[7'h00] || iholdOut !== mRegs[7'h10] || chopOut !== mRegs[7'h6C] || wrAddr !== mWrAddr) begin
        bad++; $display("[TB] FAIL rand_regs[%0d] got %h %h %h %h want %h %h %h %h", n, gconfOut, iholdOut, chopOut, wrAddr, mRegs[7'h00], mRegs[7'h10], mRegs[7'h6C], mWrAddr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gstat_read();
    test_write_chopconf();
    test_short_frame();
    test_drv_status();
    test_drv_err();
    test_reset_midframe();
    test_unimplemented();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
